// File: rtl/axil_read_arbiter_pkg.sv
// rtl/axil_read_arbiter_pkg.sv - shared state encodings, response codes and helpers for the read arbiter
package axil_arb_pkg;

  // Arbiter FSM encodings
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_ADDR    = 2'd1;
  localparam arb_state_t ST_RESP    = 2'd2;
  localparam arb_state_t ST_DELIVER = 2'd3;

  // AXI read response codes, forwarded untouched to the requester
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Modulo-n increment used to advance the round-robin pointer past the last grantee
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axil_read_arbiter_if.sv
// rtl/axil_read_arbiter_if.sv - requester, response and AXI4-Lite read bundle for the arbiter
interface axil_read_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  localparam int IDX_W = $clog2(N_REQ);

  // requester side
  logic                    enable;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [1:0]              rsp_resp;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;

  // AXI4-Lite read master toward the slave
  logic [ADDR_W-1:0]       m_araddr;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [2:0]              m_arprot;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;
  logic                    m_rready;

  // arbiter view
  modport master (
    input  enable, req_valid, req_addr, rsp_ready,
    input  m_arready, m_rdata, m_rresp, m_rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_resp, grant_id, busy,
    output m_araddr, m_arvalid, m_arprot, m_rready
  );

  // environment view (requesters plus slave)
  modport slave (
    output enable, req_valid, req_addr, rsp_ready,
    output m_arready, m_rdata, m_rresp, m_rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_resp, grant_id, busy,
    input  m_araddr, m_arvalid, m_arprot, m_rready
  );

endinterface

// File: rtl/axil_read_arbiter_rr_arbiter.sv
// rtl/axil_read_arbiter_rr_arbiter.sv - combinational round-robin picker
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  int               pos;
  logic [N_REQ-1:0] req_rot;

  // Scan circularly from ptr; the first active request found wins
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    pos       = 0;
    req_rot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos     = (int'(ptr) + i) % N_REQ;
      req_rot = req >> pos;
      if (!any_valid && req_rot[0]) begin
        any_valid = 1'b1;
        grant     = N_REQ'(1) << pos;
        idx       = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// rtl/axil_read_arbiter.sv - round-robin sharing of one AXI4-Lite read port, one read in flight
module axil_read_arbiter
  import axil_arb_pkg::*;
#(
  parameter int         N_REQ  = 4,
  parameter int         ADDR_W = 24,
  parameter int         DATA_W = 32,
  parameter logic [2:0] ARPROT = 3'b000
) (
  input logic                 ACLK,
  input logic                 ARESET,
  axil_read_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t        state_q,     state_d;
  logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]  grant_id_q,  grant_id_d;
  logic [ADDR_W-1:0] araddr_q,    araddr_d;
  logic              arvalid_q,   arvalid_d;
  logic              rready_q,    rready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [1:0]        rsp_resp_q,  rsp_resp_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              grant_ready;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Address of the requester the picker currently favours
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Only the grantee's own rsp_ready may release the response
  always_comb begin
    grant_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) grant_ready = bus.rsp_ready[i];
    end
  end

  // Read sequencing: accept -> AR handshake -> R handshake -> hand data to requester
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable && pick_any) begin
          araddr_d   = sel_addr;
          grant_id_d = pick_idx;
          arvalid_d  = 1'b1;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.m_rvalid) begin
          rready_d   = 1'b0;
          rsp_data_d = bus.m_rdata;
          rsp_resp_d = bus.m_rresp;
          for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = (grant_id_q == IDX_W'(i));
          end
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (grant_ready) begin
          rsp_valid_d = '0;
          rr_ptr_d    = IDX_W'(wrap_inc(32'(grant_id_q), N_REQ));
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE && bus.enable && !ARESET) ? pick_grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_arprot  = ARPROT;
  assign bus.m_rready  = rready_q;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// tb/tb_axil_read_arbiter.sv - directed self-checking bench for axil_read_arbiter
module tb_axil_read_arbiter;
  import axil_arb_pkg::*;

  logic ACLK;
  logic ARESET;

  axil_read_arbiter_if #(.N_REQ(4), .ADDR_W(24), .DATA_W(32)) bus ();

  axil_read_arbiter #(
    .N_REQ  (4),
    .ADDR_W (24),
    .DATA_W (32),
    .ARPROT (3'b000)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus.master)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  int          rsp_rises = 0;
  logic [3:0]  prev_rv   = 4'b0;

  always @(negedge ACLK) begin
    if (bus.rsp_valid !== 4'b0 && !$isunknown(bus.rsp_valid) && prev_rv === 4'b0) rsp_rises++;
    prev_rv = bus.rsp_valid;
  end

  int          res_grant, res_lat, res_wait;
  logic [23:0] res_addr;
  logic [31:0] res_data;
  logic [1:0]  res_resp;
  logic [3:0]  res_rspv;
  bit          res_tmo, res_stable, res_rready_ok, res_held;

  task automatic run_read(input int arlat, input int early_r, input int rlat,
                          input logic [31:0] data, input logic [1:0] resp,
                          input int rsp_wait, input bit drop);
    int t;
    res_tmo = 0; res_grant = -1; res_stable = 1; res_rready_ok = 1; res_held = 1;
    res_lat = 0; res_wait = 0; res_addr = '0; res_data = '0; res_resp = '0; res_rspv = '0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.rsp_ready = 4'b0;
    #1;
    t = 0;
    while (bus.req_ready === 4'b0 && t < 20) begin
      @(negedge ACLK); #1; t++;
    end
    res_wait = t;
    if (bus.req_ready === 4'b0) begin
      res_tmo = 1;
      return;
    end
    for (int i = 0; i < 4; i++) if (bus.req_ready[i] === 1'b1) res_grant = i;
    @(negedge ACLK); #1; res_lat = 1;
    if (drop) bus.req_valid[res_grant] = 1'b0;
    res_addr = bus.m_araddr;
    for (int k = 0; k <= arlat; k++) begin
      if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== res_addr || bus.m_rready !== 1'b0) res_stable = 0;
      bus.m_arready = (k == arlat);
      bus.m_rvalid  = (k < early_r);
      bus.m_rdata   = 32'hBAD0BAD0;
      bus.m_rresp   = 2'b11;
      @(negedge ACLK); #1; res_lat++;
    end
    bus.m_arready = 1'b0;
    for (int k = 0; k <= rlat; k++) begin
      if (bus.m_rready !== 1'b1 || bus.m_arvalid !== 1'b0 || bus.rsp_valid !== 4'b0) res_rready_ok = 0;
      bus.m_rvalid = (k == rlat);
      bus.m_rdata  = (k == rlat) ? data : 32'hBAD0BAD0;
      bus.m_rresp  = (k == rlat) ? resp : 2'b11;
      @(negedge ACLK); #1; res_lat++;
    end
    bus.m_rvalid = 1'b0;
    res_rspv = bus.rsp_valid;
    res_data = bus.rsp_data;
    res_resp = bus.rsp_resp;
    for (int k = 0; k <= rsp_wait; k++) begin
      if (bus.rsp_valid !== res_rspv || bus.rsp_data !== res_data || bus.rsp_resp !== res_resp ||
          dut.state_q !== ST_DELIVER) res_held = 0;
      bus.rsp_ready = (k == rsp_wait) ? (4'b0001 << res_grant) : ~(4'b0001 << res_grant);
      @(negedge ACLK); #1;
    end
    bus.rsp_ready = 4'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    bus.enable = 1'b1;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK); #1;
      n_checks++;
      if (bus.req_ready !== 4'b0) begin
        n_fail++; $display("FAIL reset_req_ready cycle %0d: got %b expected 0000", c, bus.req_ready);
      end
    end
    n_checks++;
    if ({bus.m_arvalid, bus.m_rready, bus.busy, bus.rsp_valid} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: arvalid=%b rready=%b busy=%b rsp_valid=%b expected all 0",
                         bus.m_arvalid, bus.m_rready, bus.busy, bus.rsp_valid);
    end
    n_checks++;
    if (bus.m_araddr !== 24'h0 || bus.rsp_data !== 32'h0 || bus.rsp_resp !== 2'b0 ||
        bus.grant_id !== 2'd0 || bus.m_arprot !== 3'b000) begin
      n_fail++; $display("FAIL reset_data: araddr=%h rsp_data=%h rsp_resp=%b grant_id=%0d arprot=%b expected zeros",
                         bus.m_araddr, bus.rsp_data, bus.rsp_resp, bus.grant_id, bus.m_arprot);
    end
    bus.req_valid = 4'h0;
    ARESET = 1'b0;
    @(negedge ACLK); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
      n_fail++; $display("FAIL reset_release: busy=%b rr_ptr=%0d expected 0/0", bus.busy, dut.rr_ptr_q);
    end
  endtask

  task automatic test_single_read();
    bus.req_addr = {24'h000400, 24'h0000A0, 24'h000200, 24'h000100};
    bus.req_addr[2*24 +: 24] = 24'h0000A0;
    bus.req_addr[1*24 +: 24] = 24'h000200;
    bus.req_valid = 4'b0100;
    run_read(0, 0, 0, 32'hDEADBEEF, RESP_OKAY, 0, 1'b1);
    n_checks++;
    if (res_tmo) begin
      n_fail++; $display("FAIL single_accept: req_ready never asserted within 20 cycles");
      return;
    end
    n_checks++;
    if (res_grant != 2 || res_addr !== 24'h0000A0) begin
      n_fail++; $display("FAIL single_grant: grant=%0d araddr=%h expected 2/0000a0", res_grant, res_addr);
    end
    n_checks++;
    if (res_lat != 3 || res_rspv !== 4'b0100) begin
      n_fail++; $display("FAIL single_latency: rsp after %0d cycles rsp_valid=%b expected 3/0100", res_lat, res_rspv);
    end
    n_checks++;
    if (res_data !== 32'hDEADBEEF || res_resp !== 2'b00) begin
      n_fail++; $display("FAIL single_data: data=%h resp=%b expected deadbeef/00", res_data, res_resp);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0 || bus.grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_idle: busy=%b rsp_valid=%b req_ready=%b grant_id=%0d expected 0/0000/0000/2",
                         bus.busy, bus.rsp_valid, bus.req_ready, bus.grant_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_g;
    bus.req_valid = 4'h0;
    ARESET = 1'b1;
    @(negedge ACLK); #1;
    ARESET = 1'b0;
    bus.req_addr  = {24'h000400, 24'h000300, 24'h000200, 24'h000100};
    bus.req_valid = 4'hF;
    for (int r = 0; r < 8; r++) begin
      exp_g = r % 4;
      run_read(0, 0, 0, 32'h10000000 + r, RESP_OKAY, 0, 1'b0);
      n_checks++;
      if (res_tmo || res_grant != exp_g) begin
        n_fail++; $display("FAIL rr_grant read %0d: grant=%0d timeout=%0d expected %0d", r, res_grant, res_tmo, exp_g);
        continue;
      end
      n_checks++;
      if (res_addr !== 24'h000100 * (exp_g + 1) || res_data !== 32'h10000000 + r) begin
        n_fail++; $display("FAIL rr_data read %0d: araddr=%h data=%h expected %h/%h",
                           r, res_addr, res_data, 24'h000100 * (exp_g + 1), 32'h10000000 + r);
      end
      n_checks++;
      if (dut.rr_ptr_q !== 2'((exp_g + 1) % 4)) begin
        n_fail++; $display("FAIL rr_ptr read %0d: got %0d expected %0d", r, dut.rr_ptr_q, (exp_g + 1) % 4);
      end
      if (r > 0) begin
        n_checks++;
        if (res_wait != 0) begin
          n_fail++; $display("FAIL rr_back_to_back read %0d: accept waited %0d cycles expected 0", r, res_wait);
        end
      end
    end
    bus.req_valid = 4'h0;
  endtask

  task automatic test_slow_slave();
    int rises0;
    bus.req_addr[1*24 +: 24] = 24'h123456;
    bus.req_valid = 4'b0010;
    rises0 = rsp_rises;
    run_read(5, 2, 3, 32'hCAFEF00D, RESP_OKAY, 0, 1'b1);
    n_checks++;
    if (res_tmo || res_grant != 1 || res_addr !== 24'h123456) begin
      n_fail++; $display("FAIL slow_grant: grant=%0d araddr=%h timeout=%0d expected 1/123456", res_grant, res_addr, res_tmo);
      return;
    end
    n_checks++;
    if (!res_stable) begin
      n_fail++; $display("FAIL slow_ar_stable: arvalid/araddr changed or rready set during ADDR (stable=%0d expected 1)", res_stable);
    end
    n_checks++;
    if (!res_rready_ok || res_lat != 11) begin
      n_fail++; $display("FAIL slow_r_phase: rready_ok=%0d latency=%0d expected 1/11", res_rready_ok, res_lat);
    end
    n_checks++;
    if (res_data !== 32'hCAFEF00D || res_resp !== 2'b00) begin
      n_fail++; $display("FAIL slow_data: data=%h resp=%b expected cafef00d/00", res_data, res_resp);
    end
    n_checks++;
    if (rsp_rises - rises0 != 1) begin
      n_fail++; $display("FAIL slow_rsp_pulses: got %0d expected 1", rsp_rises - rises0);
    end
  endtask

  task automatic test_slverr_hold();
    bus.req_addr[3*24 +: 24] = 24'h00FFFC;
    bus.req_valid = 4'b1000;
    run_read(0, 0, 0, 32'h5555AAAA, RESP_SLVERR, 4, 1'b1);
    n_checks++;
    if (res_tmo || res_grant != 3) begin
      n_fail++; $display("FAIL slverr_grant: grant=%0d timeout=%0d expected 3", res_grant, res_tmo);
      return;
    end
    n_checks++;
    if (res_resp !== 2'b10 || res_data !== 32'h5555AAAA || res_rspv !== 4'b1000) begin
      n_fail++; $display("FAIL slverr_data: resp=%b data=%h rsp_valid=%b expected 10/5555aaaa/1000",
                         res_resp, res_data, res_rspv);
    end
    n_checks++;
    if (!res_held) begin
      n_fail++; $display("FAIL slverr_hold: response changed or left DELIVER before own rsp_ready (held=%0d expected 1)", res_held);
    end
    n_checks++;
    if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
      n_fail++; $display("FAIL slverr_release: rsp_valid=%b busy=%b rr_ptr=%0d expected 0000/0/0",
                         bus.rsp_valid, bus.busy, dut.rr_ptr_q);
    end
  endtask

  task automatic test_enable_and_reset();
    bus.req_addr  = {24'h000400, 24'h000300, 24'h000200, 24'h000100};
    bus.req_valid = 4'hF;
    bus.enable    = 1'b1;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.rsp_ready = 4'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL en_first_pick: req_ready=%b expected 0001", bus.req_ready);
    end
    @(negedge ACLK); #1;
    bus.m_arready = 1'b1;
    @(negedge ACLK); #1;
    bus.m_arready = 1'b0;
    bus.enable    = 1'b0;
    n_checks++;
    if (bus.m_rready !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL en_in_resp: rready=%b busy=%b expected 1/1", bus.m_rready, bus.busy);
    end
    @(negedge ACLK); #1;
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h11112222; bus.m_rresp = RESP_OKAY;
    @(negedge ACLK); #1;
    bus.m_rvalid = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'h11112222) begin
      n_fail++; $display("FAIL en_delivered: rsp_valid=%b data=%h expected 0001/11112222", bus.rsp_valid, bus.rsp_data);
    end
    bus.rsp_ready = 4'hF;
    @(negedge ACLK); #1;
    bus.rsp_ready = 4'h0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0 || bus.m_arvalid !== 1'b0) begin
        n_fail++; $display("FAIL en_parked cycle %0d: busy=%b req_ready=%b arvalid=%b expected 0/0000/0",
                           c, bus.busy, bus.req_ready, bus.m_arvalid);
      end
      @(negedge ACLK); #1;
    end
    bus.enable = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL en_resume: req_ready=%b expected 0010", bus.req_ready);
    end
    @(negedge ACLK); #1;
    n_checks++;
    if (bus.grant_id !== 2'd1 || bus.m_arvalid !== 1'b1 || bus.m_araddr !== 24'h000200) begin
      n_fail++; $display("FAIL en_regrant: grant_id=%0d arvalid=%b araddr=%h expected 1/1/000200",
                         bus.grant_id, bus.m_arvalid, bus.m_araddr);
    end
    ARESET = 1'b1;
    @(negedge ACLK); #1;
    n_checks++;
    if (bus.m_arvalid !== 1'b0 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.req_ready !== 4'b0) begin
      n_fail++; $display("FAIL reset_in_addr: arvalid=%b busy=%b grant_id=%0d req_ready=%b expected 0/0/0/0000",
                         bus.m_arvalid, bus.busy, bus.grant_id, bus.req_ready);
    end
    ARESET = 1'b0;
    bus.req_valid = 4'h0;
    @(negedge ACLK); #1;
  endtask

  initial begin
    ARESET        = 1'b1;
    bus.enable    = 1'b0;
    bus.req_valid = 4'h0;
    bus.req_addr  = '0;
    bus.rsp_ready = 4'h0;
    bus.m_arready = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = 2'b00;
    bus.m_rvalid  = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_slow_slave();
    test_slverr_hold();
    test_enable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
